// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle for piso_serializer. The producer side is master and the serializer is slave.
// din_ready is combinational. The serial outputs are registered in the slave.
interface piso_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              data_out;
  logic              bit_valid;
  logic              frame_start;
  logic              busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  data_out,
    input  bit_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output data_out,
    output bit_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: the first bit appears one cycle after an idle accept.
// Frames run gap-free. A one-word hold buffer deasserts din_ready while it is full.
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  piso_serializer_if.slave   bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [CNT_W-1:0]  cnt;
  logic              data_out_q;
  logic              bit_valid_q;
  logic              frame_start_q;

  logic              accept;
  logic              cur_bit;
  logic [DATA_W-1:0] sreg_next;

  assign accept    = bus.din_valid && !hold_full;
  assign cur_bit   = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
  assign sreg_next = MSB_FIRST ? {sreg[DATA_W-2:0], 1'b0} : {1'b0, sreg[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sreg          <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      cnt           <= '0;
      data_out_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_out_q    <= 1'b0;
          bit_valid_q   <= 1'b0;
          frame_start_q <= 1'b0;
          if (accept) begin
            sreg  <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          data_out_q    <= cur_bit;
          bit_valid_q   <= 1'b1;
          frame_start_q <= (cnt == '0);
          if (cnt == LAST) begin
            // Explicit wrap keeps non-power-of-two widths from counting past DATA_W-1.
            cnt <= '0;
            if (hold_full) begin
              sreg      <= hold;
              hold_full <= 1'b0;
            end else if (accept) begin
              sreg <= bus.din;
            end else begin
              sreg  <= '0;
              state <= IDLE;
            end
          end else begin
            sreg <= sreg_next;
            cnt  <= cnt + CNT_W'(1);
            if (accept) begin
              hold      <= bus.din;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready   = !hold_full;
  assign bus.data_out    = data_out_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state == SHIFT) || hold_full;
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage feeding the `1001` sequence detector: accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on `data_out`, which drives the detector's `data_in`. A one-entry holding buffer gives gap-free back-to-back words. Idle cycles drive `data_out` low, so no `1` bits are injected between frames.

## Interface
- DATA_W, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order on the line: 1 = bit DATA_W-1 first, 0 = bit 0 first.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  DATA_W  parallel word.
- din_valid  input  1  `din` is valid.
- din_ready  output  1  block can accept a word this cycle; equals `!hold_full` (combinational).
- data_out  output  1  serial bit, registered; 0 when not `bit_valid`.
- bit_valid  output  1  `data_out` carries a payload bit this cycle.
- frame_start  output  1  high with the first bit of each word.
- busy  output  1  high in SHIFT state or while the hold buffer is full.

## Operation
- Handshake: a word transfers on a rising edge where `din_valid && din_ready`. `din` may change freely otherwise.
- State: shift register `sreg[DATA_W-1:0]`, bit counter `cnt` of width clog2(DATA_W), hold register plus `hold_full`, FSM {IDLE, SHIFT}.
- IDLE:
  - On accept, the word loads directly into `sreg` (bypassing hold), `cnt`=0, go to SHIFT.
  - Otherwise stay IDLE.
- SHIFT, `cnt` < DATA_W-1:
  - Emit the current bit and advance the shifter and `cnt`.
  - An accept here writes the hold register and sets `hold_full`.
- SHIFT, `cnt` = DATA_W-1 (last bit):
  - If `hold_full`: move hold into `sreg`, clear `hold_full`, `cnt`=0, stay SHIFT.
  - Else if accept this cycle: bypass into `sreg`, `cnt`=0, stay SHIFT.
  - Else go to IDLE.
- Bit selection: MSB_FIRST=1 emits `sreg[DATA_W-1]` and shifts left; MSB_FIRST=0 emits `sreg[0]` and shifts right. Vacated bits fill with 0.
- `frame_start`=1 exactly when the emitted bit is bit 0 of the count (`cnt`=0 in SHIFT).
- While `hold_full`=1, `din_ready`=0, so at most two words are in flight.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - Outputs: `data_out`=0, `bit_valid`=0, `frame_start`=0, `busy`=0, `din_ready`=1.
  - Internal: `hold_full`=0, `cnt`=0, `sreg`=0, FSM=IDLE.
- Latency: a word accepted at edge t in IDLE shows its first bit at edge t+1. Bits occupy edges t+1..t+DATA_W.
- Streaming: with `din_valid` held high, words are emitted back to back with no idle bit between frames. Sustained throughput is one word per DATA_W cycles.
- `din_ready` drops the cycle after a hold write and rises the cycle after the hold drains into `sreg` at a last-bit edge.
- Simultaneous events:
  - Hold drain and new accept cannot coincide, because ready is low while `hold_full`=1.
  - A last-bit bypass and accept coincide legally.
- Reset mid-frame: the frame aborts immediately. Partial bits are not completed, the held word is discarded, and `data_out`=0 at once.
- DATA_W is not a power of two: `cnt` wraps explicitly at DATA_W-1 and never reaches DATA_W.

## Test plan
- Reset then single word, DATA_W=8, MSB_FIRST=1, `din`=8'h99 accepted at edge 1:
  - `data_out` over edges 2..9 = 1,0,0,1,1,0,0,1; `bit_valid` high for exactly those 8 cycles; `frame_start` only at edge 2; then `data_out`=0 and `busy`=0.
  - The downstream detector reports the `1001` pattern twice.
- Back-to-back words, `din_valid` held high with 8'hA5 then 8'h3C:
  - 16 consecutive valid bits 10100101 00111100 with no gap; `frame_start` at bits 1 and 9.
  - `din_ready` low from the cycle after the second accept until the last bit of 8'hA5.
- LSB order, MSB_FIRST=0, `din`=8'h01: emits 1,0,0,0,0,0,0,0; `frame_start` with the leading 1.
- Last-bit bypass: hold empty, a second word 8'hFF presented exactly on the last bit of 8'h00.
  - Output is eight 0s immediately followed by eight 1s; `din_ready` stays high throughout.
- Backpressure: while `hold_full`, `din_valid`=1 with changing `din` values.
  - No extra words are accepted, and the emitted stream contains only the two accepted words.
- Reset mid-frame: assert `rst_n`=0 after 3 bits of 8'hF0 with a word held.
  - All outputs go to reset values immediately; after release, the next accepted word 8'h81 emits cleanly with no leftover bits.
